sgbm_frame_engine: RTL and testbench

Parametrised frame sequencer and output buffer placed between the SGBM pixel source/calculation core and downstream consumers. It starts a frame on command, gates the source enable, and captures the core's non-stallable aggregated-cost stream into a FIFO. Output leaves on a valid/ready interface with frame tags and optional winner-take-all disparity selection. The block adds backpressure throttling, overflow detection, frame framing and completion signalling.

---
 rtl/sgbm_pkg.sv | 26 ++
 rtl/sgbm_frame_engine_if.sv | 36 +++
 rtl/sgbm_out_fifo.sv | 52 +++++
 rtl/sgbm_frame_engine.sv | 184 ++++++++++++++++++
 tb/tb_sgbm_frame_engine.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sgbm_pkg.sv
// Shared types and helpers for the SGBM frame engine: FSM states, coordinate width, pixel tag bundle.
// Pure declarations; no latency or backpressure of its own.
package sgbm_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
        logic               sof;
        logic               eol;
        logic               eof;
    } pix_tag_t;

    function automatic int disp_w(input int num_disp);
        return (num_disp > 1) ? $clog2(num_disp) : 1;
    endfunction

endpackage

// File: rtl/sgbm_frame_engine_if.sv
// Core-side capture stream plus tagged valid/ready output stream of the frame engine.
// Wires only; master is the engine, slave is the core/consumer side.
interface sgbm_frame_engine_if
    import sgbm_pkg::*;
#(
    parameter int NUM_DISP = 48,
    parameter int COST_W   = 18
);
    localparam int DISP_W = disp_w(NUM_DISP);

    logic [NUM_DISP*COST_W-1:0] core_cost;
    logic [COORD_W-1:0]         core_row;
    logic [COORD_W-1:0]         core_col;
    logic                       core_valid;

    logic                       m_valid;
    logic                       m_ready;
    logic [NUM_DISP*COST_W-1:0] m_cost;
    logic [DISP_W-1:0]          m_disp;
    logic [COORD_W-1:0]         m_row;
    logic [COORD_W-1:0]         m_col;
    logic                       m_sof;
    logic                       m_eol;
    logic                       m_eof;

    modport master (
        input  core_cost, core_row, core_col, core_valid, m_ready,
        output m_valid, m_cost, m_disp, m_row, m_col, m_sof, m_eol, m_eof
    );

    modport slave (
        output core_cost, core_row, core_col, core_valid, m_ready,
        input  m_valid, m_cost, m_disp, m_row, m_col, m_sof, m_eol, m_eof
    );

endinterface

// File: rtl/sgbm_out_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; head visible the cycle after the write.
// Push while full is accepted only together with a pop; otherwise it is refused (caller sees full).
module sgbm_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sgbm_frame_engine.sv
// Frame sequencer and output buffer for the SGBM core; optional argmin stage under SGBM_WTA_EN.
// Latency core->m_valid 2 cycles (3 with SGBM_WTA_EN); core cannot stall, src_en throttles it, words hitting a full FIFO are dropped.
module sgbm_frame_engine
    import sgbm_pkg::*;
#(
    parameter int IMG_ROWS   = 200,
    parameter int IMG_COLS   = 400,
    parameter int NUM_DISP   = 48,
    parameter int COST_W     = 18,
    parameter int FIFO_DEPTH = 16,
    parameter int SLACK      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 src_en,
    sgbm_frame_engine_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [15:0]          frame_cnt
);
    localparam int CVEC_W = NUM_DISP * COST_W;
    localparam int DISP_W = disp_w(NUM_DISP);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
`ifdef SGBM_WTA_EN
    localparam int PAY_W  = DISP_W;
`else
    localparam int PAY_W  = CVEC_W;
`endif
    localparam int FW     = PAY_W + $bits(pix_tag_t);

    state_t            state, state_nxt;
    logic              core_acc, eof_acc;
    logic              cap_vld;
    logic [CVEC_W-1:0] cap_cost;
    pix_tag_t          cap_tag;
    logic              push_vld;
    logic [PAY_W-1:0]  push_pay;
    pix_tag_t          push_tag;
    logic              fifo_full, fifo_empty, fifo_pop, drop;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [FW-1:0]     fifo_dout;
    logic [PAY_W-1:0]  out_pay;
    pix_tag_t          out_tag;

    assign core_acc = (state == ST_RUN) && bus.core_valid;
    assign eof_acc  = core_acc && (bus.core_row == COORD_W'(IMG_ROWS-1))
                               && (bus.core_col == COORD_W'(IMG_COLS-1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_vld  <= 1'b0;
            cap_cost <= '0;
            cap_tag  <= '0;
        end else begin
            cap_vld <= core_acc;
            if (core_acc) begin
                cap_cost    <= bus.core_cost;
                cap_tag.row <= bus.core_row;
                cap_tag.col <= bus.core_col;
                cap_tag.sof <= (bus.core_row == '0) && (bus.core_col == '0);
                cap_tag.eol <= (bus.core_col == COORD_W'(IMG_COLS-1));
                cap_tag.eof <= (bus.core_row == COORD_W'(IMG_ROWS-1))
                            && (bus.core_col == COORD_W'(IMG_COLS-1));
            end
        end
    end

`ifdef SGBM_WTA_EN
    logic [DISP_W-1:0] amin_idx;
    logic [COST_W-1:0] amin_val;

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        amin_idx = '0;
        amin_val = cap_cost[COST_W-1:0];
        for (int d = 1; d < NUM_DISP; d++) begin
            if (cap_cost[d*COST_W +: COST_W] < amin_val) begin
                amin_val = cap_cost[d*COST_W +: COST_W];
                amin_idx = DISP_W'(d);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            push_vld <= 1'b0;
            push_pay <= '0;
            push_tag <= '0;
        end else begin
            push_vld <= cap_vld;
            push_pay <= amin_idx;
            push_tag <= cap_tag;
        end
    end
`else
    assign push_vld = cap_vld;
    assign push_pay = cap_cost;
    assign push_tag = cap_tag;
`endif

    assign fifo_pop = !fifo_empty && bus.m_ready;
    assign drop     = push_vld && fifo_full && !fifo_pop;

    sgbm_out_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_vld),
        .din   ({push_pay, push_tag}),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign {out_pay, out_tag} = fifo_dout;

    // Outputs are forced to zero while empty so nothing stale or unwritten leaks out.
    always_comb begin
        bus.m_valid = !fifo_empty;
        bus.m_cost  = '0;
        bus.m_disp  = '0;
        bus.m_row   = '0;
        bus.m_col   = '0;
        bus.m_sof   = 1'b0;
        bus.m_eol   = 1'b0;
        bus.m_eof   = 1'b0;
        if (!fifo_empty) begin
`ifdef SGBM_WTA_EN
            bus.m_disp = out_pay;
`else
            bus.m_cost = out_pay;
`endif
            bus.m_row  = out_tag.row;
            bus.m_col  = out_tag.col;
            bus.m_sof  = out_tag.sof;
            bus.m_eol  = out_tag.eol;
            bus.m_eof  = out_tag.eof;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            frame_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_DRAIN && state_nxt == ST_DONE) frame_cnt <= frame_cnt + 1'b1;
            if (state == ST_IDLE && start) overflow <= 1'b0;
            else if (drop)                 overflow <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        src_en    = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                busy   = 1'b1;
                src_en = (fifo_cnt < CNT_W'(FIFO_DEPTH - SLACK));
                if (eof_acc) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (fifo_empty && !cap_vld && !push_vld) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sgbm_frame_engine.sv
// Directed bench for sgbm_frame_engine on a 2x4 frame, 16 disparities, 16-entry FIFO with slack 4.
// Builds with or without SGBM_WTA_EN; expected words queue up as they are sent and are matched at the output.
module tb_sgbm_frame_engine;
    localparam int ROWS = 2;
    localparam int COLS = 4;
    localparam int ND   = 16;
    localparam int CW   = 18;
    localparam int CV   = ND * CW;
`ifdef SGBM_WTA_EN
    localparam int T2_SENT = 14;
`else
    localparam int T2_SENT = 13;
`endif

    typedef struct {
        logic [9:0]    row;
        logic [9:0]    col;
        logic          sof;
        logic          eol;
        logic          eof;
        logic [CV-1:0] cost;
        logic [3:0]    disp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        src_en;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] frame_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;
    int   n_extra = 0;
    exp_t exp_q[$];

    sgbm_frame_engine_if #(.NUM_DISP(ND), .COST_W(CW)) bus ();

    sgbm_frame_engine #(
        .IMG_ROWS   (ROWS),
        .IMG_COLS   (COLS),
        .NUM_DISP   (ND),
        .COST_W     (CW),
        .FIFO_DEPTH (16),
        .SLACK      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_en    (src_en),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CV-1:0] mk_cost(input int seed);
        logic [CV-1:0] v = '0;
        for (int d = 0; d < ND; d++) v[d*CW +: CW] = CW'(seed * 64 + d);
        return v;
    endfunction

    function automatic exp_t mk_exp(input int r, input int c, input logic [CV-1:0] cv, input int edisp);
        exp_t e;
        e.row = 10'(r);
        e.col = 10'(c);
        e.sof = (r == 0) && (c == 0);
        e.eol = (c == COLS - 1);
        e.eof = (r == ROWS - 1) && (c == COLS - 1);
`ifdef SGBM_WTA_EN
        e.cost = '0;
        e.disp = 4'(edisp);
`else
        e.cost = cv;
        e.disp = 4'(0 * edisp);
`endif
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input int c, input logic [CV-1:0] cv, input bit kept, input int edisp);
        bus.core_valid = 1'b1;
        bus.core_row   = 10'(r);
        bus.core_col   = 10'(c);
        bus.core_cost  = cv;
        if (kept) exp_q.push_back(mk_exp(r, c, cv, edisp));
        step();
        bus.core_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            step();
            if (done) seen = 1'b1;
        end
        check(tag, 320'(seen), 320'(1));
    endtask

    // Output scoreboard: every accepted word is matched against the oldest expected one.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (done) n_done++;
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    n_extra++;
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_row",  320'(bus.m_row),  320'(e.row));
                    check("out_col",  320'(bus.m_col),  320'(e.col));
                    check("out_sof",  320'(bus.m_sof),  320'(e.sof));
                    check("out_eol",  320'(bus.m_eol),  320'(e.eol));
                    check("out_eof",  320'(bus.m_eof),  320'(e.eof));
                    check("out_cost", 320'(bus.m_cost), 320'(e.cost));
                    check("out_disp", 320'(bus.m_disp), 320'(e.disp));
                end
            end
        end
    end

    initial begin
        logic [CV-1:0] wta_vec;
        int nsent;

        rst = 1'b0; start = 1'b0;
        bus.core_valid = 1'b0; bus.core_row = '0; bus.core_col = '0; bus.core_cost = '0;
        bus.m_ready = 1'b0;
        repeat (3) step();
        check("rst_src_en",    320'(src_en),       320'(0));
        check("rst_m_valid",   320'(bus.m_valid),  320'(0));
        check("rst_m_cost",    320'(bus.m_cost),   320'(0));
        check("rst_m_row",     320'(bus.m_row),    320'(0));
        check("rst_busy",      320'(busy),         320'(0));
        check("rst_done",      320'(done),         320'(0));
        check("rst_overflow",  320'(overflow),     320'(0));
        check("rst_frame_cnt", 320'(frame_cnt),    320'(0));
        rst = 1'b1;
        step();

        // Full 2x4 frame with the consumer always ready; also measures first-word latency.
        bus.m_ready = 1'b1;
        pulse_start();
        check("t1_busy",   320'(busy),   320'(1));
        check("t1_src_en", 320'(src_en), 320'(1));
        send(0, 0, mk_cost(1), 1'b1, 0);
        check("t1_lat_t1", 320'(bus.m_valid), 320'(0));
        step();
`ifdef SGBM_WTA_EN
        check("t1_lat_t2", 320'(bus.m_valid), 320'(0));
        step();
        check("t1_lat_t3", 320'(bus.m_valid), 320'(1));
`else
        check("t1_lat_t2", 320'(bus.m_valid), 320'(1));
`endif
        for (int i = 1; i < 8; i++) send(i / 4, i % 4, mk_cost(i + 1), 1'b1, 0);
        wait_done("t1_done");
        check("t1_frame_cnt", 320'(frame_cnt), 320'(1));
        check("t1_overflow",  320'(overflow),  320'(0));
        step();
        check("t1_done_pulses", 320'(n_done),       320'(1));
        check("t1_done_low",    320'(done),         320'(0));
        check("t1_busy_low",    320'(busy),         320'(0));
        check("t1_all_out",     320'(exp_q.size()), 320'(0));

        // Consumer stalled, core obeys src_en: throttles before the FIFO can overflow.
        bus.m_ready = 1'b0;
        pulse_start();
        nsent = 0;
        for (int k = 0; k < 30; k++) begin
            if (src_en) begin
                bus.core_valid = 1'b1;
                bus.core_row   = 10'd0;
                bus.core_col   = 10'd1;
                bus.core_cost  = mk_cost(100 + k);
                exp_q.push_back(mk_exp(0, 1, mk_cost(100 + k), 0));
                nsent++;
            end else begin
                bus.core_valid = 1'b0;
            end
            step();
        end
        bus.core_valid = 1'b0;
        check("t2_sent",     320'(nsent),    320'(T2_SENT));
        check("t2_src_en",   320'(src_en),   320'(0));
        check("t2_overflow", 320'(overflow), 320'(0));
        bus.m_ready = 1'b1;
        for (int k = 0; k < 50 && !src_en; k++) step();
        check("t2_src_resume", 320'(src_en), 320'(1));
        send(1, 3, mk_cost(150), 1'b1, 0);
        wait_done("t2_done");
        check("t2_frame_cnt", 320'(frame_cnt), 320'(2));
        check("t2_overflow2", 320'(overflow),  320'(0));
        step();
        check("t2_all_out", 320'(exp_q.size()), 320'(0));

        // Core ignores src_en: 20 words into a stalled 16-deep FIFO, last 4 dropped.
        bus.m_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 20; i++) send(0, 2, mk_cost(200 + i), (i < 16), 0);
        repeat (3) step();
        check("t3_overflow_set", 320'(overflow), 320'(1));
        bus.m_ready = 1'b1;
        repeat (25) step();
        check("t3_drained",       320'(exp_q.size()), 320'(0));
        check("t3_overflow_hold", 320'(overflow),     320'(1));
        send(1, 3, mk_cost(300), 1'b1, 0);
        wait_done("t3_done");
        check("t3_frame_cnt",    320'(frame_cnt), 320'(3));
        check("t3_overflow_end", 320'(overflow),  320'(1));
        pulse_start();
        check("t3_start_in_done", 320'(busy), 320'(0));
        step();
        check("t3_still_idle", 320'(busy),      320'(0));
        check("t3_cnt_stable", 320'(frame_cnt), 320'(3));

        // New frame clears overflow; start during RUN ignored; tied minimum picks lowest index.
        wta_vec = '0;
        for (int d = 0; d < ND; d++) wta_vec[d*CW +: CW] = CW'(100);
        wta_vec[3*CW +: CW]  = CW'(6);
        wta_vec[7*CW +: CW]  = CW'(5);
        wta_vec[12*CW +: CW] = CW'(5);
        pulse_start();
        check("t4_overflow_clr", 320'(overflow), 320'(0));
        send(0, 0, mk_cost(400), 1'b1, 0);
        send(0, 1, mk_cost(401), 1'b1, 0);
        start = 1'b1;
        send(0, 2, wta_vec, 1'b1, 7);
        start = 1'b0;
        for (int i = 3; i < 8; i++) send(i / 4, i % 4, mk_cost(400 + i), 1'b1, 0);
        wait_done("t4_done");
        check("t4_frame_cnt", 320'(frame_cnt), 320'(4));
        repeat (3) step();
        check("t4_idle",       320'(busy),      320'(0));
        check("t4_cnt_stable", 320'(frame_cnt), 320'(4));
        check("t4_done_pulses", 320'(n_done),   320'(4));

        // Reset in the middle of a frame, then a clean frame.
        bus.m_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 3; i++) send(0, i, mk_cost(500 + i), 1'b1, 0);
        rst = 1'b0;
        #1;
        check("t5_src_en",    320'(src_en),      320'(0));
        check("t5_m_valid",   320'(bus.m_valid), 320'(0));
        check("t5_m_cost",    320'(bus.m_cost),  320'(0));
        check("t5_busy",      320'(busy),        320'(0));
        check("t5_overflow",  320'(overflow),    320'(0));
        check("t5_frame_cnt", 320'(frame_cnt),   320'(0));
        exp_q.delete();
        repeat (2) step();
        rst = 1'b1;
        bus.m_ready = 1'b1;
        step();
        pulse_start();
        for (int i = 0; i < 8; i++) send(i / 4, i % 4, mk_cost(600 + i), 1'b1, 0);
        wait_done("t5_done");
        check("t5_frame_cnt2", 320'(frame_cnt), 320'(1));
        check("t5_overflow2",  320'(overflow),  320'(0));
        step();
        check("t5_all_out",  320'(exp_q.size()), 320'(0));
        check("extra_words", 320'(n_extra),      320'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
